// File: rtl/apb_ucpd_pkg.sv
// rtl/apb_ucpd_pkg.sv - shared sizes and types for the UCPD receive byte buffer
package apb_ucpd_pkg;
  localparam int UCPD_RXBUF_DEPTH = 4;
  localparam int UCPD_RXBUF_AW    = 2;
  localparam int UCPD_PSZ_W       = 10;

  typedef logic [7:0] ucpd_byte_t;
endpackage

// File: rtl/apb_ucpd_byte_fifo.sv
// rtl/apb_ucpd_byte_fifo.sv - byte FIFO with drop-on-full and same-cycle read/write handling
// Optional high-water output built only with UCPD_RXBUF_HWM_EN.
module apb_ucpd_byte_fifo
  import apb_ucpd_pkg::*;
#(
  parameter int DEPTH = UCPD_RXBUF_DEPTH,
  parameter int AW    = UCPD_RXBUF_AW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       wr,
  input  ucpd_byte_t wdata,
  input  logic       rd,
  output ucpd_byte_t rdata,
  output logic       empty,
  output logic       drop,
  output logic       hwm
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ucpd_byte_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          rd_en;
  logic          wr_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  // A read on a full FIFO frees the head slot, so the same-cycle write lands there.
  assign rd_en = rd & ~empty;
  assign wr_en = wr & (~full | rd_en);
  assign drop  = wr & ~wr_en;
  assign rdata = empty ? '0 : mem[rd_ptr];

`ifdef UCPD_RXBUF_HWM_EN
  assign hwm = (count >= (AW+1)'(DEPTH - 1));
`else
  assign hwm = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/apb_ucpd_rx_buf.sv
// rtl/apb_ucpd_rx_buf.sv - UCPD RX byte buffer: RXDR/RXNE, sticky flags, payload size, DMA request
// rx_hwm is live only when UCPD_RXBUF_HWM_EN is defined.
module apb_ucpd_rx_buf
  import apb_ucpd_pkg::*;
#(
  parameter int DEPTH = UCPD_RXBUF_DEPTH,
  parameter int AW    = UCPD_RXBUF_AW,
  parameter int PSZ_W = UCPD_PSZ_W
) (
  input  logic             ic_clk,
  input  logic             ic_rst_n,
  input  logic             ucpden,
  input  logic             rx_byte_vld,
  input  logic [7:0]       rx_byte,
  input  logic             rx_msg_start,
  input  logic             rx_msg_end,
  input  logic             rx_msg_crcok,
  input  logic             rxdr_rd,
  input  logic             rxdmaen,
  input  logic             rxovr_clr,
  input  logic             msgend_clr,
  output logic [7:0]       rxdr,
  output logic             rxne,
  output logic             rxovr,
  output logic             rxmsgend,
  output logic             rxerr,
  output logic [PSZ_W-1:0] rx_paysize,
  output logic             rx_dma_req,
  output logic             rx_hwm
);
  localparam logic [PSZ_W-1:0] PSZ_MAX = '1;

  logic             wr;
  logic             rd;
  logic             empty;
  logic             drop;
  logic             dma_wait;
  logic [PSZ_W-1:0] byte_cnt;
  logic [PSZ_W-1:0] cnt_base;
  logic [PSZ_W-1:0] cnt_next;

  assign wr = ucpden & rx_byte_vld;
  assign rd = ucpden & rxdr_rd;

  apb_ucpd_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (ic_clk),
    .rst_n (ic_rst_n),
    .flush (~ucpden),
    .wr    (wr),
    .wdata (rx_byte),
    .rd    (rd),
    .rdata (rxdr),
    .empty (empty),
    .drop  (drop),
    .hwm   (rx_hwm)
  );

  assign rxne       = ~empty;
  assign rx_dma_req = rxdmaen & rxne & ~dma_wait;

  // Dropped bytes still count toward the payload size.
  always_comb begin
    cnt_base = rx_msg_start ? '0 : byte_cnt;
    cnt_next = cnt_base;
    if (rx_byte_vld && cnt_base != PSZ_MAX) cnt_next = cnt_base + 1'b1;
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      byte_cnt   <= '0;
      rx_paysize <= '0;
      rxovr      <= 1'b0;
      rxmsgend   <= 1'b0;
      rxerr      <= 1'b0;
      dma_wait   <= 1'b0;
    end else if (!ucpden) begin
      byte_cnt <= '0;
      rxovr    <= 1'b0;
      rxmsgend <= 1'b0;
      rxerr    <= 1'b0;
      dma_wait <= 1'b0;
    end else begin
      byte_cnt <= cnt_next;
      dma_wait <= rd;
      if (drop)           rxovr <= 1'b1;
      else if (rxovr_clr) rxovr <= 1'b0;
      if (rx_msg_end) begin
        rx_paysize <= cnt_next;
        rxmsgend   <= 1'b1;
        rxerr      <= ~rx_msg_crcok;
      end else if (msgend_clr) begin
        rxmsgend <= 1'b0;
        rxerr    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_ucpd_rx_buf.sv
// tb/tb_apb_ucpd_rx_buf.sv - directed and randomized checks of apb_ucpd_rx_buf against a queue model
module tb_apb_ucpd_rx_buf;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ucpden = 1'b1;
  logic       rx_byte_vld = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_msg_start = 1'b0;
  logic       rx_msg_end = 1'b0;
  logic       rx_msg_crcok = 1'b0;
  logic       rxdr_rd = 1'b0;
  logic       rxdmaen = 1'b0;
  logic       rxovr_clr = 1'b0;
  logic       msgend_clr = 1'b0;
  logic [7:0] rxdr;
  logic       rxne, rxovr, rxmsgend, rxerr, rx_dma_req, rx_hwm;
  logic [9:0] rx_paysize;

  int checks = 0;
  int errors = 0;

  // Reference model state
  byte unsigned q[$];
  int  m_cnt = 0;
  int  m_pay = 0;
  bit  m_ovr = 0, m_me = 0, m_err = 0, m_wait = 0;

  apb_ucpd_rx_buf dut (
    .ic_clk       (clk),
    .ic_rst_n     (rst_n),
    .ucpden       (ucpden),
    .rx_byte_vld  (rx_byte_vld),
    .rx_byte      (rx_byte),
    .rx_msg_start (rx_msg_start),
    .rx_msg_end   (rx_msg_end),
    .rx_msg_crcok (rx_msg_crcok),
    .rxdr_rd      (rxdr_rd),
    .rxdmaen      (rxdmaen),
    .rxovr_clr    (rxovr_clr),
    .msgend_clr   (msgend_clr),
    .rxdr         (rxdr),
    .rxne         (rxne),
    .rxovr        (rxovr),
    .rxmsgend     (rxmsgend),
    .rxerr        (rxerr),
    .rx_paysize   (rx_paysize),
    .rx_dma_req   (rx_dma_req),
    .rx_hwm       (rx_hwm)
  );

  always #5 clk = ~clk;

  function automatic bit exp_hwm();
`ifdef UCPD_RXBUF_HWM_EN
    return q.size() >= DEPTH - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_rxdr();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  // One clock: capture inputs, advance the model by the behavioural rules, drop pulses.
  task automatic step();
    bit vld = rx_byte_vld, rd = rxdr_rd, st = rx_msg_start, en = rx_msg_end;
    bit crc = rx_msg_crcok, oc = rxovr_clr, mc = msgend_clr, on = ucpden;
    byte unsigned b = rx_byte;
    int sz;
    bit rd_ok, ovr_set;
    @(posedge clk);
    #1;
    if (!on) begin
      q.delete();
      m_cnt = 0; m_ovr = 0; m_me = 0; m_err = 0; m_wait = 0;
    end else begin
      sz = q.size();
      rd_ok = rd && sz > 0;
      ovr_set = 0;
      if (rd_ok) void'(q.pop_front());
      if (vld) begin
        if (sz < DEPTH || rd_ok) q.push_back(b);
        else ovr_set = 1;
      end
      if (st) m_cnt = 0;
      if (vld && m_cnt < 1023) m_cnt++;
      if (en) begin
        m_pay = m_cnt; m_me = 1; m_err = !crc;
      end else if (mc) begin
        m_me = 0; m_err = 0;
      end
      if (ovr_set) m_ovr = 1;
      else if (oc) m_ovr = 0;
      m_wait = rd;
    end
    rx_byte_vld = 0; rxdr_rd = 0; rx_msg_start = 0; rx_msg_end = 0;
    rxovr_clr = 0; msgend_clr = 0;
  endtask

  task automatic put(input logic [7:0] b);
    rx_byte_vld = 1; rx_byte = b;
    step();
  endtask

  task automatic test_reset();
    #2;
    checks += 6;
    if (rxdr !== 8'h00)      begin errors++; $display("FAIL reset_rxdr got %h exp 00", rxdr); end
    if (rxne !== 1'b0)       begin errors++; $display("FAIL reset_rxne got %b exp 0", rxne); end
    if (rxovr !== 1'b0)      begin errors++; $display("FAIL reset_rxovr got %b exp 0", rxovr); end
    if (rxmsgend !== 1'b0)   begin errors++; $display("FAIL reset_rxmsgend got %b exp 0", rxmsgend); end
    if (rx_paysize !== 10'd0) begin errors++; $display("FAIL reset_paysize got %0d exp 0", rx_paysize); end
    if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL reset_dma got %b exp 0", rx_dma_req); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic_rw();
    put(8'hA5);
    put(8'h3C);
    checks += 2;
    if (rxdr !== 8'hA5) begin errors++; $display("FAIL basic_head got %h exp a5", rxdr); end
    if (rxne !== 1'b1)  begin errors++; $display("FAIL basic_rxne got %b exp 1", rxne); end
    rxdr_rd = 1; step();
    checks += 2;
    if (rxdr !== 8'h3C) begin errors++; $display("FAIL basic_second got %h exp 3c", rxdr); end
    if (rxne !== 1'b1)  begin errors++; $display("FAIL basic_rxne1 got %b exp 1", rxne); end
    rxdr_rd = 1; step();
    checks += 3;
    if (rxne !== 1'b0)  begin errors++; $display("FAIL basic_empty got %b exp 0", rxne); end
    if (rxdr !== 8'h00) begin errors++; $display("FAIL basic_rxdr0 got %h exp 00", rxdr); end
    if (rxovr !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b exp 0", rxovr); end
    rxdr_rd = 1; step();
    checks++;
    if (rxne !== 1'b0)  begin errors++; $display("FAIL basic_rd_empty got %b exp 0", rxne); end
  endtask

  task automatic test_overrun();
    logic [7:0] b[5];
    rx_msg_start = 1; step();
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      put(b[i]);
    end
    checks++;
    if (rxovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", rxovr); end
    rx_msg_end = 1; rx_msg_crcok = 1; step();
    checks++;
    if (rx_paysize !== 10'd5) begin errors++; $display("FAIL ovr_paysize got %0d exp 5", rx_paysize); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxdr !== b[i]) begin errors++; $display("FAIL ovr_data%0d got %h exp %h", i, rxdr, b[i]); end
      rxdr_rd = 1; step();
    end
    checks++;
    if (rxne !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b exp 0", rxne); end
    rxovr_clr = 1; msgend_clr = 1; step();
    checks++;
    if (rxovr !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", rxovr); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_seq[4] = '{8'h22, 8'h33, 8'h44, 8'h77};
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    rx_byte_vld = 1; rx_byte = 8'h77; rxdr_rd = 1; step();
    checks++;
    if (rxovr !== 1'b0) begin errors++; $display("FAIL full_rw_ovr got %b exp 0", rxovr); end
    checks++;
    if (exp_hwm() !== rx_hwm) begin errors++; $display("FAIL full_rw_hwm got %b exp %b", rx_hwm, exp_hwm()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxdr !== exp_seq[i]) begin errors++; $display("FAIL full_rw_data%0d got %h exp %h", i, rxdr, exp_seq[i]); end
      rxdr_rd = 1; step();
    end
    checks++;
    if (rxne !== 1'b0) begin errors++; $display("FAIL full_rw_empty got %b exp 0", rxne); end
  endtask

  task automatic test_msg_end();
    rx_msg_start = 1; step();
    put(8'h01); put(8'h02); put(8'h03);
    rx_msg_end = 1; rx_msg_crcok = 0; step();
    checks += 3;
    if (rxmsgend !== 1'b1)    begin errors++; $display("FAIL msg_end got %b exp 1", rxmsgend); end
    if (rxerr !== 1'b1)       begin errors++; $display("FAIL msg_err got %b exp 1", rxerr); end
    if (rx_paysize !== 10'd3) begin errors++; $display("FAIL msg_paysize got %0d exp 3", rx_paysize); end
    msgend_clr = 1; step();
    checks += 2;
    if (rxmsgend !== 1'b0) begin errors++; $display("FAIL msg_clr got %b exp 0", rxmsgend); end
    if (rxerr !== 1'b0)    begin errors++; $display("FAIL msg_err_clr got %b exp 0", rxerr); end
    rx_msg_start = 1; rx_byte_vld = 1; rx_byte = 8'h04; step();
    rx_msg_end = 1; rx_msg_crcok = 1; msgend_clr = 1; rx_byte_vld = 1; rx_byte = 8'h05; step();
    checks += 3;
    if (rxmsgend !== 1'b1)    begin errors++; $display("FAIL msg_set_wins got %b exp 1", rxmsgend); end
    if (rxerr !== 1'b0)       begin errors++; $display("FAIL msg_crcok got %b exp 0", rxerr); end
    if (rx_paysize !== 10'd2) begin errors++; $display("FAIL msg_paysize2 got %0d exp 2", rx_paysize); end
    while (q.size() != 0) begin rxdr_rd = 1; step(); end
    msgend_clr = 1; step();
  endtask

  task automatic test_dma();
    rxdmaen = 1;
    put(8'hD1); put(8'hD2);
    checks++;
    if (rx_dma_req !== 1'b1) begin errors++; $display("FAIL dma_req1 got %b exp 1", rx_dma_req); end
    rxdr_rd = 1; step();
    checks += 2;
    if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL dma_gap1 got %b exp 0", rx_dma_req); end
    if (rxdr !== 8'hD2)      begin errors++; $display("FAIL dma_data got %h exp d2", rxdr); end
    step();
    checks++;
    if (rx_dma_req !== 1'b1) begin errors++; $display("FAIL dma_req2 got %b exp 1", rx_dma_req); end
    rxdr_rd = 1; step();
    checks++;
    if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL dma_gap2 got %b exp 0", rx_dma_req); end
    step();
    checks++;
    if (rx_dma_req !== 1'b0) begin errors++; $display("FAIL dma_empty got %b exp 0", rx_dma_req); end
    rxdmaen = 0;
  endtask

  task automatic test_flush();
    rx_msg_start = 1; step();
    for (int i = 0; i < 5; i++) put(8'(8'h60 + i));
    rxdr_rd = 1; step();
    rx_msg_end = 1; rx_msg_crcok = 1; step();
`ifdef UCPD_RXBUF_HWM_EN
    checks++;
    if (rx_hwm !== 1'b1) begin errors++; $display("FAIL flush_hwm got %b exp 1", rx_hwm); end
`endif
    checks++;
    if (rxovr !== 1'b1) begin errors++; $display("FAIL flush_pre_ovr got %b exp 1", rxovr); end
    ucpden = 0; rx_byte_vld = 1; rx_byte = 8'hEE; step();
    ucpden = 1;
    checks += 5;
    if (rxne !== 1'b0)        begin errors++; $display("FAIL flush_rxne got %b exp 0", rxne); end
    if (rxovr !== 1'b0)       begin errors++; $display("FAIL flush_ovr got %b exp 0", rxovr); end
    if (rxmsgend !== 1'b0)    begin errors++; $display("FAIL flush_msgend got %b exp 0", rxmsgend); end
    if (rxdr !== 8'h00)       begin errors++; $display("FAIL flush_rxdr got %h exp 00", rxdr); end
    if (rx_paysize !== 10'd5) begin errors++; $display("FAIL flush_paysize got %0d exp 5", rx_paysize); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rx_byte_vld  = ($urandom_range(0, 99) < 45);
      rx_byte      = 8'($urandom);
      rxdr_rd      = ($urandom_range(0, 99) < 40);
      rx_msg_start = ($urandom_range(0, 99) < 5);
      rx_msg_end   = ($urandom_range(0, 99) < 5);
      rx_msg_crcok = 1'($urandom);
      rxovr_clr    = ($urandom_range(0, 99) < 8);
      msgend_clr   = ($urandom_range(0, 99) < 8);
      ucpden       = ($urandom_range(0, 99) >= 3);
      if ($urandom_range(0, 19) == 0) rxdmaen = ~rxdmaen;
      step();
      checks += 8;
      if (rxdr !== exp_rxdr()) begin errors++; $display("FAIL rnd_rxdr@%0d got %h exp %h", n, rxdr, exp_rxdr()); end
      if (rxne !== (q.size() != 0)) begin errors++; $display("FAIL rnd_rxne@%0d got %b exp %b", n, rxne, q.size() != 0); end
      if (rxovr !== m_ovr) begin errors++; $display("FAIL rnd_rxovr@%0d got %b exp %b", n, rxovr, m_ovr); end
      if (rxmsgend !== m_me) begin errors++; $display("FAIL rnd_rxmsgend@%0d got %b exp %b", n, rxmsgend, m_me); end
      if (rxerr !== m_err) begin errors++; $display("FAIL rnd_rxerr@%0d got %b exp %b", n, rxerr, m_err); end
      if (rx_paysize !== 10'(m_pay)) begin errors++; $display("FAIL rnd_paysize@%0d got %0d exp %0d", n, rx_paysize, m_pay); end
      if (rx_dma_req !== (rxdmaen && q.size() != 0 && !m_wait)) begin
        errors++; $display("FAIL rnd_dma@%0d got %b exp %b", n, rx_dma_req, rxdmaen && q.size() != 0 && !m_wait);
      end
      if (rx_hwm !== exp_hwm()) begin errors++; $display("FAIL rnd_hwm@%0d got %b exp %b", n, rx_hwm, exp_hwm()); end
    end
    ucpden = 1; rxdmaen = 0;
  endtask

  task automatic test_async_reset();
    put(8'h5A); put(8'hC3);
    rx_msg_end = 1; step();
    #3 rst_n = 0;
    #1;
    checks += 4;
    if (rxne !== 1'b0)        begin errors++; $display("FAIL areset_rxne got %b exp 0", rxne); end
    if (rxdr !== 8'h00)       begin errors++; $display("FAIL areset_rxdr got %h exp 00", rxdr); end
    if (rxmsgend !== 1'b0)    begin errors++; $display("FAIL areset_msgend got %b exp 0", rxmsgend); end
    if (rx_paysize !== 10'd0) begin errors++; $display("FAIL areset_paysize got %0d exp 0", rx_paysize); end
    rst_n = 1;
    q.delete();
    m_cnt = 0; m_pay = 0; m_ovr = 0; m_me = 0; m_err = 0; m_wait = 0;
    put(8'h9B);
    checks++;
    if (rxdr !== 8'h9B) begin errors++; $display("FAIL areset_after got %h exp 9b", rxdr); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_overrun();
    test_full_rw();
    test_msg_end();
    test_dma();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_ucpd_rx_buf.md
Name: apb_ucpd_rx_buf

Overview:
Receive byte buffer between the UCPD protocol core's RX output and the APB register/DMA interface. It captures decoded payload bytes (CRC stripped) and presents the head byte as RXDR. It generates the RXNE, RXOVR and RXMSGEND status, a DMA request, and the received payload size. It is placed downstream of the core's rx_data / rxfifo write strobe and upstream of the register file.

Parameters:
DEPTH, 4, FIFO depth in bytes; power of 2, range 2..16
AW, 2, pointer width, equal to log2(DEPTH)
PSZ_W, 10, width of the payload size counter

Ports:
ic_clk  in  1  UCPD kernel clock; all logic on rising edge
ic_rst_n  in  1  asynchronous active-low reset
ucpden  in  1  peripheral enable; low means synchronous flush
rx_byte_vld  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received payload byte (CRC removed)
rx_msg_start  in  1  one-cycle pulse at SOP detection
rx_msg_end  in  1  one-cycle pulse at EOP detection
rx_msg_crcok  in  1  CRC result, sampled with rx_msg_end
rxdr_rd  in  1  one-cycle pulse when APB reads RXDR or DMA acks
rxdmaen  in  1  RX DMA enable
rxovr_clr  in  1  write-1-clear pulse for RXOVR
msgend_clr  in  1  write-1-clear pulse for RXMSGEND and RXERR
rxdr  out  8  head byte; 0x00 when empty
rxne  out  1  FIFO not empty
rxovr  out  1  sticky overrun flag
rxmsgend  out  1  sticky message-end flag
rxerr  out  1  sticky CRC-error flag, valid with rxmsgend
rx_paysize  out  PSZ_W  byte count of last completed message
rx_dma_req  out  1  DMA request
rx_hwm  out  1  high-water mark (optional feature)

Behaviour:
- Reset: all outputs 0, pointers 0, count 0, internal byte counter 0.
- Storage: DEPTH x 8 register array with rd_ptr, wr_ptr (AW bits, natural wrap) and count (AW+1 bits). rxdr = mem[rd_ptr] when count != 0, else 0x00. rxne = (count != 0).
- Write: on rx_byte_vld with count < DEPTH, store at wr_ptr and increment wr_ptr. The byte is visible on rxdr/rxne the next cycle (latency 1).
- Full write: rx_byte_vld with count == DEPTH and no rxdr_rd in the same cycle drops the byte and sets rxovr next cycle. Stored data is not modified.
- Full, simultaneous read and write: both are performed, count is unchanged, no overrun.
- Read: rxdr_rd with count != 0 increments rd_ptr. rxdr_rd on empty is ignored and causes no pointer movement.
- Empty, simultaneous read and write: the write is performed, the read is ignored, count becomes 1.
- Byte counter:
  - Cleared by rx_msg_start.
  - Incremented on every rx_byte_vld, including dropped bytes; saturates at 2^PSZ_W-1.
  - Same-cycle rx_msg_start and rx_byte_vld: the counter becomes 1.
- Message end: on rx_msg_end, rx_paysize <= byte counter (including a same-cycle byte), rxmsgend <= 1, rxerr <= ~rx_msg_crcok.
- Clear precedence:
  - A set event in the same cycle as msgend_clr wins.
  - A set event in the same cycle as rxovr_clr wins.
- rx_dma_req:
  - Equals rxdmaen & rxne & ~dma_wait. dma_wait is set by rxdr_rd and cleared the following cycle, which guarantees one idle cycle between requests.
  - With rxdmaen=0 it stays 0.
- ucpden low:
  - Same cycle (synchronous): pointers, count, byte counter and all sticky flags are cleared; rx_paysize holds its value.
  - All inputs except the clear pulses are ignored while ucpden is low.
- Mid-message reset: ic_rst_n low at any time restores reset values asynchronously.
- No state machine beyond the FIFO and flags; all control is counter-based.

Optional Feature:
Macro UCPD_RXBUF_HWM_EN.
- Defined: rx_hwm = (count >= DEPTH-1), registered, with the same latency as rxne; intended for the IMR interrupt.
- Undefined: rx_hwm is tied to 0 and no comparator logic is built.

Decomposition:
- Package apb_ucpd_pkg holds:
  - UCPD_RXBUF_DEPTH = 4
  - UCPD_RXBUF_AW = 2
  - UCPD_PSZ_W = 10
  - typedef ucpd_byte_t (8-bit)
- Sub-module apb_ucpd_byte_fifo contains the storage, pointers, count, full/empty logic and same-cycle read/write handling.
- The top level holds the flags, the byte counter and the DMA handshake.

Test Plan:
- Write 0xA5, 0x3C, then issue 2 rxdr_rd → rxdr shows 0xA5 then 0x3C; rxne falls after the second read; rxovr=0.
- Write 5 bytes with no reads, DEPTH=4 → bytes 1-4 retained; rxovr=1 after the 5th; at rx_msg_end, rx_paysize=5.
- Full FIFO, simultaneous rxdr_rd + rx_byte_vld(0x77) → count stays 4; 0x77 is read last; rxovr=0.
- Issue rx_msg_start, 3 bytes, rx_msg_end with rx_msg_crcok=0 → rxmsgend=1, rxerr=1, rx_paysize=3; msgend_clr clears both; msgend_clr in the same cycle as the next rx_msg_end leaves them set.
- With rxdmaen=1 and 2 bytes buffered, ack each request with rxdr_rd → rx_dma_req deasserts for 1 cycle after each ack and ends at 0 when empty.
- With 3 bytes buffered and flags set, drop ucpden → next cycle rxne=0, rxovr=0, rxmsgend=0, rxdr=0x00, rx_paysize unchanged. With UCPD_RXBUF_HWM_EN, rx_hwm=1 at 3 bytes before the drop.
